// File: rtl/chunked_subtractor_pkg.sv
// chunked_subtractor_pkg: shared state encoding and sizing helpers for the chunked subtractor
package chunked_subtractor_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction
   // never returns 0 so a single-chunk build still gets a legal 1-bit index
   function automatic int clog2(input int v);
      int r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/chunked_subtractor_if.sv
// chunked_subtractor_if: operand and result valid/ready channels of the chunked subtractor
interface chunked_subtractor_if #(parameter int WIDTH = 32);
   logic             in_valid, in_ready, bin, out_valid, out_ready;
   logic [WIDTH-1:0] a, b;
   logic [WIDTH:0]   diff;
   modport slave (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff);
   modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff);
endinterface

// File: rtl/chunked_subtractor_sub_slice.sv
// chunked_subtractor_sub_slice: combinational CHUNK-bit subtract with borrow in and out
module chunked_subtractor_sub_slice #(parameter int CHUNK = 8) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_bin,
   output logic [CHUNK-1:0] o_diff,
   output logic             o_bout
);
   logic [CHUNK:0] w_full;
   assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_bin};
   assign o_diff = w_full[CHUNK-1:0];
   assign o_bout = w_full[CHUNK];
endmodule

// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle a-b-bin over one shared CHUNK-bit slice with a registered borrow
module chunked_subtractor
   import chunked_subtractor_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CHUNK   = 8,
   parameter int HAS_BIN = 0
) (
   input logic clk,
   input logic rst_n,
   chunked_subtractor_if.slave io
);
   localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
   localparam int PW     = NCHUNK * CHUNK;
   localparam int IW     = clog2(NCHUNK);
   state_t           r_state, w_next;
   logic [IW-1:0]    r_idx;
   logic             r_borrow, w_bout, w_last, w_bin;
   logic [PW-1:0]    r_a, r_b, r_res;
   logic [CHUNK-1:0] w_d;
   assign w_last       = r_idx == IW'(NCHUNK - 1);
   assign w_bin        = (HAS_BIN != 0) && io.bin;
   assign io.in_ready  = r_state == IDLE;
   assign io.out_valid = r_state == DONE;
   // padded result bits are never exposed; the borrow through zero padding equals the bit WIDTH-1 borrow
   assign io.diff      = {r_borrow, r_res[WIDTH-1:0]};
   chunked_subtractor_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a    (r_a[r_idx*CHUNK +: CHUNK]),
      .i_b    (r_b[r_idx*CHUNK +: CHUNK]),
      .i_bin  (r_borrow),
      .o_diff (w_d),
      .o_bout (w_bout)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = io.in_valid ? BUSY : IDLE;
         BUSY:    w_next = w_last ? DONE : BUSY;
         DONE:    w_next = io.out_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_borrow <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && io.in_valid) begin
            r_a      <= PW'(io.a);
            r_b      <= PW'(io.b);
            r_borrow <= w_bin;
            r_idx    <= '0;
         end else if (r_state == BUSY) begin
            r_res[r_idx*CHUNK +: CHUNK] <= w_d;
            r_borrow                    <= w_bout;
            r_idx                       <= r_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: directed vectors on WIDTH=34 builds (CHUNK=8 without/with borrow-in, CHUNK=40 with borrow-in)
module tb_chunked_subtractor;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [33:0] t_a = '0, t_b = '0;
   logic        t_bin = 1'b0, t_valid = 1'b0, t_oready = 1'b0;
   int          n_chk = 0, n_pass = 0;
   logic [34:0] d0, d1, d2;
   int          l0, l1, l2;
   always #5 clk = ~clk;
   chunked_subtractor_if #(.WIDTH(34)) f0 ();
   chunked_subtractor_if #(.WIDTH(34)) f1 ();
   chunked_subtractor_if #(.WIDTH(34)) f2 ();
   assign f0.a = t_a;  assign f0.b = t_b;  assign f0.bin = t_bin;  assign f0.in_valid = t_valid;  assign f0.out_ready = t_oready;
   assign f1.a = t_a;  assign f1.b = t_b;  assign f1.bin = t_bin;  assign f1.in_valid = t_valid;  assign f1.out_ready = t_oready;
   assign f2.a = t_a;  assign f2.b = t_b;  assign f2.bin = t_bin;  assign f2.in_valid = t_valid;  assign f2.out_ready = t_oready;
   chunked_subtractor #(.WIDTH(34), .CHUNK(8), .HAS_BIN(0)) u0 (.clk(clk), .rst_n(rst_n), .io(f0.slave));
   chunked_subtractor #(.WIDTH(34), .CHUNK(8), .HAS_BIN(1)) u1 (.clk(clk), .rst_n(rst_n), .io(f1.slave));
   chunked_subtractor #(.WIDTH(34), .CHUNK(40), .HAS_BIN(1)) u2 (.clk(clk), .rst_n(rst_n), .io(f2.slave));

   // one transaction on all three builds; latency counts edges after the accept edge, -1 on timeout
   task automatic txn(input logic [33:0] a, input logic [33:0] b, input logic bin);
      @(negedge clk);
      t_a = a; t_b = b; t_bin = bin; t_valid = 1'b1;
      @(posedge clk); #1 t_valid = 1'b0;
      d0 = 'x; d1 = 'x; d2 = 'x; l0 = -1; l1 = -1; l2 = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (f0.out_valid && l0 < 0) begin l0 = c; d0 = f0.diff; end
         if (f1.out_valid && l1 < 0) begin l1 = c; d1 = f1.diff; end
         if (f2.out_valid && l2 < 0) begin l2 = c; d2 = f2.diff; end
      end
      t_oready = 1'b1;
      @(posedge clk); #1 t_oready = 1'b0;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (f0.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", f0.in_ready); else n_pass++;
      n_chk++; if (f0.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", f0.out_valid); else n_pass++;
      n_chk++; if (f0.diff !== 35'h0) $display("FAIL reset_diff got %h want 0", f0.diff); else n_pass++;
      n_chk++; if (f2.out_valid !== 1'b0) $display("FAIL reset_out_valid_c40 got %b want 0", f2.out_valid); else n_pass++;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_basic;
      txn(34'h3_0000_0005, 34'h1_0000_0003, 1'b0);
      n_chk++; if (d0 !== 35'h2_0000_0002) $display("FAIL basic_diff got %h want 200000002", d0); else n_pass++;
      n_chk++; if (l0 !== 5) $display("FAIL basic_latency got %0d want 5", l0); else n_pass++;
      n_chk++; if (d1 !== 35'h2_0000_0002) $display("FAIL basic_diff_bin got %h want 200000002", d1); else n_pass++;
      n_chk++; if (d2 !== 35'h2_0000_0002) $display("FAIL basic_diff_c40 got %h want 200000002", d2); else n_pass++;
      n_chk++; if (l2 !== 1) $display("FAIL basic_latency_c40 got %0d want 1", l2); else n_pass++;
   endtask

   task automatic test_underflow;
      txn(34'h0, 34'h1, 1'b0);
      n_chk++; if (d0 !== 35'h7_FFFF_FFFF) $display("FAIL underflow_diff got %h want 7ffffffff", d0); else n_pass++;
      n_chk++; if (d0[34] !== 1'b1) $display("FAIL underflow_borrow got %b want 1", d0[34]); else n_pass++;
      txn(34'h5, 34'h5, 1'b0);
      n_chk++; if (d0 !== 35'h0) $display("FAIL equal_diff got %h want 0", d0); else n_pass++;
   endtask

   task automatic test_cross_chunk;
      txn(34'h1_0000_0000, 34'h1, 1'b0);
      n_chk++; if (d0 !== 35'h0_FFFF_FFFF) $display("FAIL cross_diff got %h want 0ffffffff", d0); else n_pass++;
      n_chk++; if (d0[34] !== 1'b0) $display("FAIL cross_borrow got %b want 0", d0[34]); else n_pass++;
   endtask

   task automatic test_borrow_in;
      txn(34'h0, 34'h0, 1'b1);
      n_chk++; if (d1 !== 35'h7_FFFF_FFFF) $display("FAIL bin_wrap got %h want 7ffffffff", d1); else n_pass++;
      n_chk++; if (d2 !== 35'h7_FFFF_FFFF) $display("FAIL bin_wrap_c40 got %h want 7ffffffff", d2); else n_pass++;
      n_chk++; if (d0 !== 35'h0) $display("FAIL bin_ignored got %h want 0", d0); else n_pass++;
      txn(34'd10, 34'd3, 1'b1);
      n_chk++; if (d1 !== 35'd6) $display("FAIL bin_small got %h want 6", d1); else n_pass++;
      n_chk++; if (d0 !== 35'd7) $display("FAIL bin_small_ignored got %h want 7", d0); else n_pass++;
   endtask

   task automatic test_backpressure;
      int c;
      @(negedge clk);
      t_a = 34'h2_1234_5678; t_b = 34'h0_1111_1111; t_bin = 1'b0; t_valid = 1'b1;
      @(posedge clk); #1 t_valid = 1'b0;
      c = 0;
      while (!f0.out_valid && c < 20) begin @(posedge clk); #1 c++; end
      n_chk++; if (c !== 5) $display("FAIL bp_latency got %0d want 5", c); else n_pass++;
      for (int i = 0; i < 7; i++) begin
         t_valid = i[0]; t_a = 34'($urandom); t_b = 34'($urandom);
         @(posedge clk); #1;
         n_chk++; if (f0.diff !== 35'h2_0123_4567) $display("FAIL bp_hold_diff got %h want 201234567", f0.diff); else n_pass++;
         n_chk++; if (f0.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", f0.in_ready); else n_pass++;
         n_chk++; if (f0.out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", f0.out_valid); else n_pass++;
      end
      // both handshakes offered in DONE: only the output side may complete this edge
      t_a = 34'd100; t_b = 34'd300; t_valid = 1'b1; t_oready = 1'b1;
      @(posedge clk); #1 t_oready = 1'b0;
      n_chk++; if (f0.out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", f0.out_valid); else n_pass++;
      n_chk++; if (f0.in_ready !== 1'b1) $display("FAIL bp_release_idle got %b want 1", f0.in_ready); else n_pass++;
      @(posedge clk); #1 t_valid = 1'b0;
      n_chk++; if (f0.in_ready !== 1'b0) $display("FAIL bp_second_accept got %b want 0", f0.in_ready); else n_pass++;
      c = 0;
      while (!f0.out_valid && c < 20) begin @(posedge clk); #1 c++; end
      n_chk++; if (c !== 5) $display("FAIL bp_second_latency got %0d want 5", c); else n_pass++;
      n_chk++; if (f0.diff !== 35'h7_FFFF_FF38) $display("FAIL bp_second_diff got %h want 7ffffff38", f0.diff); else n_pass++;
      t_oready = 1'b1;
      @(posedge clk); #1 t_oready = 1'b0;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      t_a = 34'h3_FFFF_FFFF; t_b = 34'h1; t_bin = 1'b0; t_valid = 1'b1;
      @(posedge clk); #1 t_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (f0.in_ready !== 1'b0) $display("FAIL mid_busy got %b want 0", f0.in_ready); else n_pass++;
      n_chk++; if (f2.out_valid !== 1'b1) $display("FAIL mid_c40_done got %b want 1", f2.out_valid); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (f0.in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", f0.in_ready); else n_pass++;
      n_chk++; if (f0.out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", f0.out_valid); else n_pass++;
      n_chk++; if (f2.out_valid !== 1'b0) $display("FAIL mid_c40_drop got %b want 0", f2.out_valid); else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      txn(34'd7, 34'd2, 1'b0);
      n_chk++; if (d0 !== 35'd5) $display("FAIL mid_fresh_diff got %h want 5", d0); else n_pass++;
      n_chk++; if (l0 !== 5) $display("FAIL mid_fresh_latency got %0d want 5", l0); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_underflow;
      test_cross_chunk;
      test_borrow_in;
      test_backpressure;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
